// File: rtl/vid_timing_gen_pkg.sv
// Shared video-timing definitions: default parameter width and the region
// indices used by the per-axis decoders.
package vid_timing_gen_pkg;

  localparam int PARAM_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    REGION_SYNC = 2'd0,
    REGION_BP   = 2'd1,
    REGION_ACT  = 2'd2,
    REGION_FP   = 2'd3
  } region_e;

endpackage

// File: rtl/vid_timing_gen_axis_counter.sv
// One timing axis: position counter, frame-start shadow of the axis lengths,
// and sync/back-porch/active/front-porch region decode.
module vid_axis_counter
  import vid_timing_gen_pkg::*;
#(
  parameter int PARAM_WIDTH = PARAM_WIDTH_DEF
) (
  input  logic                   I_CLK,
  input  logic                   I_RSTN,
  input  logic                   clear_i,
  input  logic                   step_i,
  input  logic                   load_i,
  input  logic                   bypass_i,
  input  logic [PARAM_WIDTH-1:0] sw_cap_i,
  input  logic [PARAM_WIDTH-1:0] bp_cap_i,
  input  logic [PARAM_WIDTH-1:0] act_cap_i,
  input  logic [PARAM_WIDTH-1:0] fp_cap_i,
  input  logic [PARAM_WIDTH-1:0] total_i,
  output logic [PARAM_WIDTH-1:0] cnt_o,
  output logic [PARAM_WIDTH-1:0] pos_o,
  output logic                   last_o,
  output logic                   sync_o,
  output logic                   act_o
);

  localparam int W = PARAM_WIDTH;

  typedef struct packed {
    logic [W-1:0] sw;
    logic [W-1:0] bp;
    logic [W-1:0] act;
    logic [W-1:0] fp;
    logic [W-1:0] total;
  } axis_cfg_t;

  axis_cfg_t    cap_c;
  axis_cfg_t    cfg_c;
  axis_cfg_t    sh_q;
  axis_cfg_t    sh_d;
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   cnt_ext_c;
  logic [W:0]   sum_sb_c;
  logic [W:0]   sum_sba_c;
  region_e      region_c;
  logic         fp_unused;

  assign cap_c = '{sw: sw_cap_i, bp: bp_cap_i, act: act_cap_i, fp: fp_cap_i, total: total_i};

  // On the enable-rise cycle the counters already sit at 0, so the decode must
  // see the values being loaded rather than the stale shadow.
  assign cfg_c  = bypass_i ? cap_c : sh_q;
  assign sh_d   = load_i ? cap_c : sh_q;
  assign last_o = (cnt_q >= cfg_c.total);

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Sums carry one extra bit so large lengths never wrap the comparisons.
  assign cnt_ext_c = {1'b0, cnt_q};
  assign sum_sb_c  = {1'b0, cfg_c.sw} + {1'b0, cfg_c.bp};
  assign sum_sba_c = sum_sb_c + {1'b0, cfg_c.act};

  always_comb begin
    region_c = REGION_FP;
    if (cnt_ext_c < {1'b0, cfg_c.sw}) begin
      region_c = REGION_SYNC;
    end else if (cnt_ext_c < sum_sb_c) begin
      region_c = REGION_BP;
    end else if (cnt_ext_c < sum_sba_c) begin
      region_c = REGION_ACT;
    end
  end

  assign cnt_o  = cnt_q;
  assign pos_o  = cnt_q - sum_sb_c[W-1:0];
  assign sync_o = (region_c == REGION_SYNC);
  assign act_o  = (region_c == REGION_ACT);

  // The front-porch length only acts through the total; it is held for visibility.
  assign fp_unused = ^sh_q.fp;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/vid_timing_gen.sv
// Video timing generator: horizontal/vertical axis counters with frame-start
// parameter shadowing and registered sync, data-enable, position and pulses.
module vid_timing_gen
  import vid_timing_gen_pkg::*;
#(
  parameter int PARAM_WIDTH = PARAM_WIDTH_DEF
) (
  input  logic                   I_CLK,
  input  logic                   I_RSTN,
  input  logic                   i_en,
  input  logic [PARAM_WIDTH-1:0] i_hsw_cap,
  input  logic [PARAM_WIDTH-1:0] i_hbp_cap,
  input  logic [PARAM_WIDTH-1:0] i_hact_cap,
  input  logic [PARAM_WIDTH-1:0] i_hfp_cap,
  input  logic [PARAM_WIDTH-1:0] i_vsw_cap,
  input  logic [PARAM_WIDTH-1:0] i_vbp_cap,
  input  logic [PARAM_WIDTH-1:0] i_vact_cap,
  input  logic [PARAM_WIDTH-1:0] i_vfp_cap,
  input  logic [PARAM_WIDTH-1:0] i_htotal,
  input  logic [PARAM_WIDTH-1:0] i_vtotal,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_de,
  output logic [PARAM_WIDTH-1:0] o_hpos,
  output logic [PARAM_WIDTH-1:0] o_vpos,
  output logic                   o_line_start,
  output logic                   o_frame_start
);

  localparam int W = PARAM_WIDTH;

  typedef struct packed {
    logic         hsync;
    logic         vsync;
    logic         de;
    logic         line_start;
    logic         frame_start;
    logic [W-1:0] hpos;
    logic [W-1:0] vpos;
  } vid_out_t;

  logic         en_q;
  logic         rise_c;
  logic         wrap_c;
  logic         load_c;
  logic [W-1:0] h_cnt;
  logic [W-1:0] v_cnt;
  logic [W-1:0] h_pos;
  logic [W-1:0] v_pos;
  logic         h_last;
  logic         v_last;
  logic         h_sync;
  logic         v_sync;
  logic         h_act;
  logic         v_act;
  vid_out_t     out_d;
  vid_out_t     out_q;

  // A frame starts either when both counters wrap or when enable rises.
  assign rise_c = i_en & ~en_q;
  assign wrap_c = i_en & h_last & v_last;
  assign load_c = rise_c | wrap_c;

  vid_axis_counter #(.PARAM_WIDTH(W)) u_h_axis (
    .I_CLK     (I_CLK),
    .I_RSTN    (I_RSTN),
    .clear_i   (~i_en),
    .step_i    (i_en),
    .load_i    (load_c),
    .bypass_i  (rise_c),
    .sw_cap_i  (i_hsw_cap),
    .bp_cap_i  (i_hbp_cap),
    .act_cap_i (i_hact_cap),
    .fp_cap_i  (i_hfp_cap),
    .total_i   (i_htotal),
    .cnt_o     (h_cnt),
    .pos_o     (h_pos),
    .last_o    (h_last),
    .sync_o    (h_sync),
    .act_o     (h_act)
  );

  vid_axis_counter #(.PARAM_WIDTH(W)) u_v_axis (
    .I_CLK     (I_CLK),
    .I_RSTN    (I_RSTN),
    .clear_i   (~i_en),
    .step_i    (i_en & h_last),
    .load_i    (load_c),
    .bypass_i  (rise_c),
    .sw_cap_i  (i_vsw_cap),
    .bp_cap_i  (i_vbp_cap),
    .act_cap_i (i_vact_cap),
    .fp_cap_i  (i_vfp_cap),
    .total_i   (i_vtotal),
    .cnt_o     (v_cnt),
    .pos_o     (v_pos),
    .last_o    (v_last),
    .sync_o    (v_sync),
    .act_o     (v_act)
  );

  always_comb begin
    out_d = '0;
    if (i_en) begin
      out_d.hsync       = h_sync;
      out_d.vsync       = v_sync;
      out_d.de          = h_act & v_act;
      out_d.line_start  = (h_cnt == '0);
      out_d.frame_start = (h_cnt == '0) && (v_cnt == '0);
      if (out_d.de) begin
        out_d.hpos = h_pos;
        out_d.vpos = v_pos;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      en_q  <= 1'b0;
      out_q <= '0;
    end else begin
      en_q  <= i_en;
      out_q <= out_d;
    end
  end

  assign o_hsync       = out_q.hsync;
  assign o_vsync       = out_q.vsync;
  assign o_de          = out_q.de;
  assign o_hpos        = out_q.hpos;
  assign o_vpos        = out_q.vpos;
  assign o_line_start  = out_q.line_start;
  assign o_frame_start = out_q.frame_start;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Self-checking bench for vid_timing_gen: frame-index reference model compared
// every cycle, plus directed frame measurements with hand-computed counts.
module tb_vid_timing_gen;

  localparam int W = 16;

  logic         I_CLK = 1'b0;
  logic         I_RSTN;
  logic         i_en;
  logic [W-1:0] i_hsw_cap, i_hbp_cap, i_hact_cap, i_hfp_cap;
  logic [W-1:0] i_vsw_cap, i_vbp_cap, i_vact_cap, i_vfp_cap;
  logic [W-1:0] i_htotal, i_vtotal;
  logic         o_hsync, o_vsync, o_de, o_line_start, o_frame_start;
  logic [W-1:0] o_hpos, o_vpos;

  int n_checks = 0;
  int n_errors = 0;

  vid_timing_gen #(.PARAM_WIDTH(W)) dut (
    .I_CLK         (I_CLK),
    .I_RSTN        (I_RSTN),
    .i_en          (i_en),
    .i_hsw_cap     (i_hsw_cap),
    .i_hbp_cap     (i_hbp_cap),
    .i_hact_cap    (i_hact_cap),
    .i_hfp_cap     (i_hfp_cap),
    .i_vsw_cap     (i_vsw_cap),
    .i_vbp_cap     (i_vbp_cap),
    .i_vact_cap    (i_vact_cap),
    .i_vfp_cap     (i_vfp_cap),
    .i_htotal      (i_htotal),
    .i_vtotal      (i_vtotal),
    .o_hsync       (o_hsync),
    .o_vsync       (o_vsync),
    .o_de          (o_de),
    .o_hpos        (o_hpos),
    .o_vpos        (o_vpos),
    .o_line_start  (o_line_start),
    .o_frame_start (o_frame_start)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_out(logic hs, logic vs, logic de, logic ls, logic fs,
                                           logic [W-1:0] hp, logic [W-1:0] vp);
    return {27'd0, hs, vs, de, ls, fs, hp, vp};
  endfunction

  // ---------------- reference model: position from a frame-relative clock index
  typedef struct packed {
    int hsw; int hbp; int hact; int hfp;
    int vsw; int vbp; int vact; int vfp;
    int htot; int vtot;
  } tcfg_t;

  typedef struct packed {
    tcfg_t       cfg;
    int          k;
    logic [63:0] out;
  } mstep_t;

  function automatic mstep_t model_step(bit en_prev, int k_in, tcfg_t cfg_in, tcfg_t port);
    mstep_t r;
    tcfg_t  c;
    int     k, line, flen, x, y, hs0, vs0;
    bit     de;
    c    = en_prev ? cfg_in : port;
    k    = en_prev ? k_in : 0;
    line = c.htot + 1;
    flen = line * (c.vtot + 1);
    x    = k % line;
    y    = k / line;
    hs0  = c.hsw + c.hbp;
    vs0  = c.vsw + c.vbp;
    de   = (x >= hs0) && (x < hs0 + c.hact) && (y >= vs0) && (y < vs0 + c.vact);
    r.out = pack_out(x < c.hsw, y < c.vsw, de, x == 0, k == 0,
                     de ? W'(x - hs0) : '0, de ? W'(y - vs0) : '0);
    r.cfg = c;
    r.k   = k + 1;
    if (r.k == flen) begin
      r.k   = 0;
      r.cfg = port;
    end
    return r;
  endfunction

  tcfg_t       port_cfg;
  tcfg_t       m_cfg;
  int          m_k;
  bit          m_en_prev;
  mstep_t      m_next;
  logic [63:0] exp_vec = '0;
  bit          cmp_en  = 1'b0;

  always_comb begin
    port_cfg = '{hsw: int'(i_hsw_cap), hbp: int'(i_hbp_cap), hact: int'(i_hact_cap),
                 hfp: int'(i_hfp_cap), vsw: int'(i_vsw_cap), vbp: int'(i_vbp_cap),
                 vact: int'(i_vact_cap), vfp: int'(i_vfp_cap),
                 htot: int'(i_htotal), vtot: int'(i_vtotal)};
    m_next = model_step(m_en_prev, m_k, m_cfg, port_cfg);
  end

  always @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN || !i_en) begin
      m_en_prev <= 1'b0;
      m_k       <= 0;
      m_cfg     <= '0;
      exp_vec   <= '0;
    end else begin
      m_en_prev <= 1'b1;
      m_k       <= m_next.k;
      m_cfg     <= m_next.cfg;
      exp_vec   <= m_next.out;
    end
  end

  always @(negedge I_CLK) begin
    if (cmp_en)
      check("cycle_outputs",
            pack_out(o_hsync, o_vsync, o_de, o_line_start, o_frame_start, o_hpos, o_vpos),
            exp_vec);
  end

  // ---------------- stimulus helpers
  task automatic set_timing(input int hsw, input int hbp, input int hact, input int hfp,
                            input int vsw, input int vbp, input int vact, input int vfp);
    i_hsw_cap  = W'(hsw);  i_hbp_cap = W'(hbp);  i_hact_cap = W'(hact); i_hfp_cap = W'(hfp);
    i_vsw_cap  = W'(vsw);  i_vbp_cap = W'(vbp);  i_vact_cap = W'(vact); i_vfp_cap = W'(vfp);
    i_htotal   = W'(hsw + hbp + hact + hfp - 1);
    i_vtotal   = W'(vsw + vbp + vact + vfp - 1);
  endtask

  logic [W-1:0] hpos_seen [4];
  int           n_hpos;
  logic [W-1:0] last_vpos;

  // Counts one frame from a frame_start pulse up to the next one; optionally
  // switches to the 'narrow' horizontal timing after chg_at clocks.
  task automatic measure_frame(input int chg_at, output int cyc, output int de_n,
                               output int hs_n, output int vs_n, output int ls_n);
    int guard;
    guard = 0; cyc = 0; de_n = 0; hs_n = 0; vs_n = 0; ls_n = 0; n_hpos = 0;
    while (o_frame_start !== 1'b1 && guard < 200) begin
      @(negedge I_CLK);
      guard++;
    end
    check("frame_start_seen", 64'(o_frame_start), 64'd1);
    do begin
      cyc++;
      if (o_de === 1'b1) begin
        de_n++;
        if (n_hpos < 4) begin
          hpos_seen[n_hpos] = o_hpos;
          n_hpos++;
        end
        last_vpos = o_vpos;
      end
      hs_n += int'(o_hsync);
      vs_n += int'(o_vsync);
      ls_n += int'(o_line_start);
      if (cyc == chg_at) set_timing(2, 3, 2, 1, 1, 1, 2, 1);
      @(negedge I_CLK);
    end while (o_frame_start !== 1'b1 && cyc < 200);
  endtask

  task automatic wait_de();
    int guard;
    guard = 0;
    while (o_de !== 1'b1 && guard < 100) begin
      @(negedge I_CLK);
      guard++;
    end
    check("de_reached", 64'(o_de), 64'd1);
  endtask

  int cyc, de_n, hs_n, vs_n, ls_n;

  initial begin
    I_RSTN = 1'b0;
    i_en   = 1'b0;
    set_timing(2, 3, 4, 1, 1, 1, 2, 1);
    repeat (3) @(negedge I_CLK);
    check("reset_outputs",
          pack_out(o_hsync, o_vsync, o_de, o_line_start, o_frame_start, o_hpos, o_vpos), '0);
    cmp_en = 1'b1;
    I_RSTN = 1'b1;
    @(negedge I_CLK);
    check("idle_outputs",
          pack_out(o_hsync, o_vsync, o_de, o_line_start, o_frame_start, o_hpos, o_vpos), '0);

    // First enabled cycle: frame start one clock later, line 0 in both syncs.
    i_en = 1'b1;
    @(negedge I_CLK);
    check("first_frame_start", 64'(o_frame_start), 64'd1);
    check("first_hsync", 64'(o_hsync), 64'd1);
    check("first_vsync", 64'(o_vsync), 64'd1);

    measure_frame(-1, cyc, de_n, hs_n, vs_n, ls_n);
    check("f1_clocks", 64'(cyc), 64'd50);
    check("f1_de", 64'(de_n), 64'd8);
    check("f1_hsync", 64'(hs_n), 64'd10);
    check("f1_vsync", 64'(vs_n), 64'd10);
    check("f1_lines", 64'(ls_n), 64'd5);
    for (int i = 0; i < 4; i++) check("f1_hpos_seq", 64'(hpos_seen[i]), 64'(i));
    check("f1_last_vpos", 64'(last_vpos), 64'd1);

    // Mid-frame change to hact=2: this frame unchanged, next one narrower.
    measure_frame(20, cyc, de_n, hs_n, vs_n, ls_n);
    check("f2_clocks", 64'(cyc), 64'd50);
    check("f2_de", 64'(de_n), 64'd8);
    measure_frame(-1, cyc, de_n, hs_n, vs_n, ls_n);
    check("f3_clocks", 64'(cyc), 64'd40);
    check("f3_de", 64'(de_n), 64'd4);
    check("f3_lines", 64'(ls_n), 64'd5);
    check("f3_hsync", 64'(hs_n), 64'd10);

    // Drop enable mid-line, restore timing while idle, re-enable.
    wait_de();
    i_en = 1'b0;
    set_timing(2, 3, 4, 1, 1, 1, 2, 1);
    @(negedge I_CLK);
    check("disable_zero",
          pack_out(o_hsync, o_vsync, o_de, o_line_start, o_frame_start, o_hpos, o_vpos), '0);
    repeat (3) @(negedge I_CLK);
    check("disabled_zero",
          pack_out(o_hsync, o_vsync, o_de, o_line_start, o_frame_start, o_hpos, o_vpos), '0);
    i_en = 1'b1;
    @(negedge I_CLK);
    check("reenable_frame_start", 64'(o_frame_start), 64'd1);
    measure_frame(-1, cyc, de_n, hs_n, vs_n, ls_n);
    check("f4_clocks", 64'(cyc), 64'd50);
    check("f4_de", 64'(de_n), 64'd8);

    // Reset in the active area: immediate clear, then a clean restart.
    wait_de();
    #2 I_RSTN = 1'b0;
    #1 check("reset_mid_active",
             pack_out(o_hsync, o_vsync, o_de, o_line_start, o_frame_start, o_hpos, o_vpos), '0);
    @(negedge I_CLK);
    I_RSTN = 1'b1;
    @(negedge I_CLK);
    check("restart_frame_start", 64'(o_frame_start), 64'd1);
    measure_frame(-1, cyc, de_n, hs_n, vs_n, ls_n);
    check("f5_clocks", 64'(cyc), 64'd50);
    check("f5_de", 64'(de_n), 64'd8);

    // Zero active width: no DE at all, syncs keep their period.
    set_timing(2, 3, 0, 1, 1, 1, 2, 1);
    measure_frame(-1, cyc, de_n, hs_n, vs_n, ls_n);
    measure_frame(-1, cyc, de_n, hs_n, vs_n, ls_n);
    check("hact0_clocks", 64'(cyc), 64'd30);
    check("hact0_de", 64'(de_n), 64'd0);
    check("hact0_hsync", 64'(hs_n), 64'd10);
    check("hact0_vsync", 64'(vs_n), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
